// File: rtl/mux_arb_stream_nb.sv
// rtl/mux_arb_stream_nb.sv - registered N:1 valid/ready stream mux with round-robin or fixed-select arbitration
module mux_arb_stream_nb #(
  parameter int n = 8,
  parameter int m = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MODE,
  input  logic [m-1:0]          SEL,
  input  logic [(2**m)*n-1:0]   D_IN,
  input  logic [(2**m)-1:0]     VALID_IN,
  output logic [(2**m)-1:0]     READY_IN,
  output logic [n-1:0]          D_OUT,
  output logic [m-1:0]          CH_OUT,
  output logic                  VALID_OUT,
  input  logic                  READY_OUT
);

  localparam int CH = 2**m;

  logic [n-1:0] d_out_q,     d_out_d;
  logic [m-1:0] ch_out_q,    ch_out_d;
  logic         valid_out_q, valid_out_d;
  logic [m-1:0] ptr_q,       ptr_d;

  logic         ld_en;
  logic         gnt_found;
  logic [m-1:0] gnt_idx;
  logic [m-1:0] cand;
  logic         take;

  // Output register may refill whenever it is empty or draining this cycle
  assign ld_en = !valid_out_q | READY_OUT;

  // Grant: fixed select honours only SEL; round-robin scans upward from the pointer, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (MODE) begin
      if (VALID_IN[SEL]) begin
        gnt_found = 1'b1;
        gnt_idx   = SEL;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        cand = ptr_q + m'(i);
        if (!gnt_found && VALID_IN[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  assign take = ld_en & gnt_found & !RST;

  // One-hot acknowledge to the granted source; suppressed during reset and stall
  always_comb begin
    READY_IN = '0;
    if (take) READY_IN[gnt_idx] = 1'b1;
  end

  // Next-state for the output register and round-robin pointer
  always_comb begin
    d_out_d     = d_out_q;
    ch_out_d    = ch_out_q;
    valid_out_d = valid_out_q;
    ptr_d       = ptr_q;
    if (take) begin
      d_out_d     = D_IN[int'(gnt_idx)*n +: n];
      ch_out_d    = gnt_idx;
      valid_out_d = 1'b1;
      ptr_d       = gnt_idx + m'(1);
    end else if (valid_out_q && READY_OUT) begin
      valid_out_d = 1'b0;
    end
  end

  // State registers; reset discards any held word and rewinds the pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      d_out_q     <= '0;
      ch_out_q    <= '0;
      valid_out_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      d_out_q     <= d_out_d;
      ch_out_q    <= ch_out_d;
      valid_out_q <= valid_out_d;
      ptr_q       <= ptr_d;
    end
  end

  assign D_OUT     = d_out_q;
  assign CH_OUT    = ch_out_q;
  assign VALID_OUT = valid_out_q;

endmodule

// File: tb/tb_mux_arb_stream_nb.sv
// tb/tb_mux_arb_stream_nb.sv - self-checking bench for mux_arb_stream_nb
module tb_mux_arb_stream_nb;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [M-1:0]    sel;
  logic [CH*N-1:0] d_in;
  logic [CH-1:0]   valid_in;
  logic [CH-1:0]   ready_in;
  logic [N-1:0]    d_out;
  logic [M-1:0]    ch_out;
  logic            valid_out;
  logic            ready_out;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  int m_ov, m_od, m_oc, m_ptr;

  mux_arb_stream_nb #(.n(N), .m(M)) dut (
    .CLK(clk), .RST(rst), .MODE(mode), .SEL(sel), .D_IN(d_in),
    .VALID_IN(valid_in), .READY_IN(ready_in), .D_OUT(d_out),
    .CH_OUT(ch_out), .VALID_OUT(valid_out), .READY_OUT(ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // channel that wins under the arbitration rules, or -1 for none
  function automatic int model_grant(input int md, input int sl, input logic [CH-1:0] v, input int p);
    if (md != 0) return v[sl] ? sl : -1;
    for (int i = 0; i < CH; i++) begin
      if (v[(p + i) % CH]) return (p + i) % CH;
    end
    return -1;
  endfunction

  // one clock: drive at negedge, check acks, then check registers after the edge
  task automatic cycle(input logic r, input logic md, input int sl, input logic [CH-1:0] v,
                       input logic ro, input logic [CH*N-1:0] din);
    int g;
    logic [CH-1:0] exp_rdy;
    @(negedge clk);
    rst = r; mode = md; sel = M'(sl); valid_in = v; ready_out = ro; d_in = din;
    #1;
    g = model_grant(md, sl, v, m_ptr);
    exp_rdy = '0;
    if (!r && (m_ov == 0 || ro) && g >= 0) exp_rdy[g] = 1'b1;
    chk("ready_in", 32'(ready_in), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_ov = 0; m_od = 0; m_oc = 0; m_ptr = 0;
    end else if (exp_rdy != 0) begin
      m_od = int'(din[g*N +: N]); m_oc = g; m_ov = 1; m_ptr = (g + 1) % CH;
    end else if (m_ov != 0 && ro) begin
      m_ov = 0;
    end
    #1;
    chk("valid_out", 32'(valid_out), 32'(m_ov));
    chk("d_out",     32'(d_out),     32'(m_od));
    chk("ch_out",    32'(ch_out),    32'(m_oc));
  endtask

  logic [CH*N-1:0] dat_a;

  initial begin
    m_ov = 0; m_od = 0; m_oc = 0; m_ptr = 0;
    rst = 1'b1; mode = 1'b0; sel = '0; valid_in = '0; ready_out = 1'b0; d_in = '0;
    dat_a = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // reset held with every source valid
    cycle(1, 0, 0, 4'hF, 1, dat_a);
    cycle(1, 0, 0, 4'hF, 1, dat_a);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_d", 32'(d_out), 32'd0);

    // round-robin fairness
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 4'hF, 1, dat_a);
      chk("rr_d_const", 32'(d_out), 32'hA0 + 32'(i % 4));
      chk("rr_ch_const", 32'(ch_out), 32'(i % 4));
    end

    // one fixed grant on ch2 leaves the pointer at 3, then skip/wrap in RR
    cycle(0, 1, 2, 4'h4, 1, dat_a);
    cycle(0, 0, 0, 4'h5, 1, dat_a);
    chk("skip_ch0", 32'(ch_out), 32'd0);
    cycle(0, 0, 0, 4'h5, 1, dat_a);
    chk("skip_ch2", 32'(ch_out), 32'd2);
    cycle(0, 0, 0, 4'h5, 1, dat_a);
    chk("skip_ch0b", 32'(ch_out), 32'd0);

    // fixed mode ignores other valid channels
    cycle(0, 1, 2, 4'hB, 1, dat_a);
    cycle(0, 1, 2, 4'hB, 1, dat_a);
    chk("fixed_idle", 32'(valid_out), 32'd0);
    cycle(0, 1, 2, 4'h4, 1, {8'h00, 8'h5C, 8'h00, 8'h00});
    chk("fixed_d", 32'(d_out), 32'h5C);
    chk("fixed_ch", 32'(ch_out), 32'd2);

    // back-pressure with new inputs waiting
    cycle(0, 0, 0, 4'hF, 1, dat_a);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'hF, 0, {8'h13, 8'h12, 8'h11, 8'h10});
    cycle(0, 0, 0, 4'hF, 1, {8'h13, 8'h12, 8'h11, 8'h10});

    // reset during a stall, then lowest valid channel wins first
    cycle(0, 0, 0, 4'hF, 0, dat_a);
    cycle(1, 0, 0, 4'hF, 0, dat_a);
    cycle(0, 0, 0, 4'h6, 1, dat_a);
    chk("post_reset_ch", 32'(ch_out), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom), int'($urandom_range(0, CH - 1)),
            4'($urandom), ($urandom_range(0, 3) != 0), 32'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
